mem_access_unit: RTL

Sequential load/store data-path unit sitting between the MEM-stage pipeline register and a synchronous data memory. It replaces the purely combinational byte-enable pattern logic with a parametrised FSM. The FSM generates byte enables and shifted write data, and aligns and sign/zero-extends load data. Misaligned accesses are either split into two word accesses or rejected with an error response.

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signal bundle for mem_access_unit.
// The slave modport is the unit's view; the master modport is the pipeline/memory side.
interface mem_access_unit_if #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
);
  localparam int NB = XLEN / 8;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic                 rsp_valid;
  logic                 rsp_err;
  logic [XLEN-1:0]      rsp_rdata;
  logic                 mem_en;
  logic [NB-1:0]        mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [XLEN-1:0]      mem_wdata;
  logic [XLEN-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a synchronous data RAM: byte lanes,
// store shifting, load alignment/extension, and split or rejected misaligned accesses.
module mem_access_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_SIZE        = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = 2 * XLEN;
  localparam int IW   = $clog2(CW);

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_DONE, S_ERR} state_t;

  state_t               r_state, w_next;
  logic                 r_we, r_unsigned, r_cross;
  logic [1:0]           r_size;
  logic [ADDR_SIZE-1:0] r_addr, r_mem_addr;
  logic [XLEN-1:0]      r_wdata, r_lo_hold, r_rsp_rdata, r_mem_wdata;

  // Decode of the incoming request, used only for the IDLE decision.
  logic [3:0]      w_req_bytes;
  logic [OFFW-1:0] w_req_off;
  logic            w_req_mis, w_req_illegal, w_req_cross;

  assign w_req_bytes   = 4'd1 << bus.req_size;
  assign w_req_off     = bus.req_addr[OFFW-1:0];
  assign w_req_mis     = (bus.req_addr[3:0] & (w_req_bytes - 4'd1)) != 4'd0;
  assign w_req_illegal = (bus.req_size == 2'b11) && (XLEN == 32);
  assign w_req_cross   = (5'(w_req_off) + 5'(w_req_bytes)) > 5'(NB);

  // Datapath on the latched request.
  logic [OFFW-1:0]      w_off;
  logic [3:0]           w_bytes;
  logic [2*NB-1:0]      w_size_mask, w_we_wide;
  logic [XLEN-1:0]      w_keep, w_load_ext;
  logic [CW-1:0]        w_wdata_wide, w_cat, w_shift;
  logic [IW-1:0]        w_top;
  logic                 w_sign;
  logic [ADDR_SIZE-1:0] w_base, w_base_hi;

  assign w_off   = r_addr[OFFW-1:0];
  assign w_bytes = 4'd1 << r_size;

  genvar gi;
  generate
    for (gi = 0; gi < 2 * NB; gi++) begin : g_size_mask
      assign w_size_mask[gi] = (32'(gi) < 32'(w_bytes));
    end
    for (gi = 0; gi < NB; gi++) begin : g_keep
      assign w_keep[8*gi +: 8] = {8{w_size_mask[gi]}};
    end
  endgenerate

  // Low half of each double-width vector feeds ACC0, high half feeds ACC1.
  assign w_we_wide    = w_size_mask << w_off;
  assign w_wdata_wide = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_base       = {r_addr[ADDR_SIZE-1:OFFW], {OFFW{1'b0}}};
  assign w_base_hi    = w_base + ADDR_SIZE'(NB);

  assign w_cat      = r_cross ? {bus.mem_rdata, r_lo_hold} : {{XLEN{1'b0}}, bus.mem_rdata};
  assign w_shift    = w_cat >> {w_off, 3'b000};
  assign w_top      = IW'({w_bytes, 3'b000} - 7'd1);
  assign w_sign     = w_shift[w_top] && !r_unsigned;
  assign w_load_ext = (w_shift[XLEN-1:0] & w_keep) | (w_sign ? ~w_keep : {XLEN{1'b0}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.req_valid) begin
        if (w_req_illegal || (w_req_mis && (ALLOW_MISALIGNED == 0))) w_next = S_ERR;
        else                                                          w_next = S_ACC0;
      end
      S_ACC0:  w_next = r_cross ? S_ACC1 : S_DONE;
      S_ACC1:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (r_state == S_IDLE);
    bus.rsp_valid = (r_state == S_DONE) || (r_state == S_ERR);
    bus.rsp_err   = (r_state == S_ERR);
    bus.rsp_rdata = ((r_state == S_DONE) && !r_we) ? w_load_ext : r_rsp_rdata;
    bus.mem_en    = 1'b0;
    bus.mem_we    = '0;
    bus.mem_addr  = r_mem_addr;
    bus.mem_wdata = r_mem_wdata;
    if (r_state == S_ACC0) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = r_we ? w_we_wide[NB-1:0] : '0;
      bus.mem_addr  = w_base;
      bus.mem_wdata = w_wdata_wide[XLEN-1:0];
    end else if (r_state == S_ACC1) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = r_we ? w_we_wide[2*NB-1:NB] : '0;
      bus.mem_addr  = w_base_hi;
      bus.mem_wdata = w_wdata_wide[CW-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_cross     <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_lo_hold   <= '0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (r_state == S_IDLE && bus.req_valid) begin
        r_we       <= bus.req_we;
        r_unsigned <= bus.req_unsigned;
        r_cross    <= w_req_cross;
        r_size     <= bus.req_size;
        r_addr     <= bus.req_addr;
        r_wdata    <= bus.req_wdata;
      end
      // Memory address/data hold their last driven value between accesses.
      if (r_state == S_ACC0 || r_state == S_ACC1) begin
        r_mem_addr  <= bus.mem_addr;
        r_mem_wdata <= bus.mem_wdata;
      end
      if (r_state == S_ACC1) r_lo_hold <= bus.mem_rdata;
      if (r_state == S_DONE && !r_we) r_rsp_rdata <= w_load_ext;
    end
  end
endmodule
